// File: rtl/dm_lsu.sv
// Single-clock data memory with load/store alignment. After every reset it sweeps
// all words to zero before it accepts requests. Loads return two edges after
// acceptance. Misaligned or illegal accesses report an error pulse instead.
module dm_lsu #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [31:0]       wd,
    output logic              ready,
    output logic              rd_valid,
    output logic [31:0]       rd,
    output logic              addr_err
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 2 ** IDX_W;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        mem [DEPTH];
    logic [31:0]        rdata_q;

    logic               accept, legal;
    logic               ld_acc, st_acc, err_acc;

    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [3:0]         wr_be;
    logic [31:0]        wr_data;

    // Load pipeline: stage 1 holds the RAM read, stage 2 the extended result
    logic               ld_q, err_q, sign_q;
    logic [1:0]         off_q, size_q;
    logic               rd_valid_q, addr_err_q;
    logic [31:0]        rd_q, ld_ext;
    logic [7:0]         byte_v;
    logic [15:0]        half_v;

    assign ready   = (state_q == StRun);
    assign accept  = req & ready;
    assign ld_acc  = accept & legal & ~we;
    assign st_acc  = accept & legal & we;
    assign err_acc = accept & ~legal;

    // Alignment check on the incoming request
    always_comb begin
        legal = 1'b0;
        case (size)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~addr[0];
            2'b10:   legal = (addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // Sweep counter and state: INIT clears one word per cycle, then RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == StInit) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
                state_d = StRun;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write port select: sweep zeros during INIT, lane-replicated stores in RUN
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = addr[ADDR_W-1:2];
        wr_be   = 4'b0000;
        wr_data = 32'h0;
        if (state_q == StInit) begin
            wr_en   = 1'b1;
            wr_idx  = cnt_q;
            wr_be   = 4'b1111;
        end else if (st_acc) begin
            wr_en = 1'b1;
            case (size)
                2'b00: begin
                    wr_be   = 4'b0001 << addr[1:0];
                    wr_data = {4{wd[7:0]}};
                end
                2'b01: begin
                    wr_be   = addr[1] ? 4'b1100 : 4'b0011;
                    wr_data = {2{wd[15:0]}};
                end
                default: begin
                    wr_be   = 4'b1111;
                    wr_data = wd;
                end
            endcase
        end
    end

    // RAM: byte-enabled write and synchronous read; no writes while reset is high
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        if (ld_acc) begin
            rdata_q <= mem[addr[ADDR_W-1:2]];
        end
    end

    // Lane select and sign/zero extension of the registered read word
    always_comb begin
        byte_v = 8'(rdata_q >> {off_q, 3'b000});
        half_v = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (size_q)
            2'b00:   ld_ext = {{24{sign_q & byte_v[7]}}, byte_v};
            2'b01:   ld_ext = {{16{sign_q & half_v[15]}}, half_v};
            default: ld_ext = rdata_q;
        endcase
    end

    // Result pipeline; reset drops any load or error still in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_q       <= 1'b0;
            err_q      <= 1'b0;
            off_q      <= 2'b00;
            size_q     <= 2'b00;
            sign_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            rd_q       <= 32'h0;
        end else begin
            ld_q       <= ld_acc;
            err_q      <= err_acc;
            if (ld_acc) begin
                off_q  <= addr[1:0];
                size_q <= size;
                sign_q <= sign;
            end
            rd_valid_q <= ld_q;
            addr_err_q <= err_q;
            if (ld_q) begin
                rd_q <= ld_ext;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign addr_err = addr_err_q;
    assign rd       = rd_q;

endmodule

// File: doc/dm_lsu.md
# dm_lsu

Parametrised single-clock data memory with an integrated load/store alignment unit. It replaces the fixed 4 KB byte-enable data memory in the CPU datapath. It also adds:
- sub-word store lane generation;
- sign/zero-extended sub-word loads;
- misalignment detection;
- a post-reset clearing sweep, so the memory contents are known after every reset.

The MEM stage drives it directly with the full byte address and an access size.

## Interface

Parameters:
- ADDR_W, default 12: byte-address width. Depth = 2^(ADDR_W-2) 32-bit words. Legal range 4..16.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  access request. Accepted only when req && ready.
- we  input  1  1 = store, 0 = load. Sampled on acceptance.
- addr  input  ADDR_W  byte address.
- size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- sign  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- wd  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- ready  output  1  block can accept a request this cycle.
- rd_valid  output  1  one-cycle pulse: rd holds the result of a load.
- rd  output  32  extended load data.
- addr_err  output  1  one-cycle pulse: the access accepted in the previous cycle was misaligned or illegal.

## Operation

- One clock, clk. Reset is synchronous and active-high (reset). There are no asynchronous paths.

States:
- INIT: a word counter runs from 0 to DEPTH-1, writing 32'h0 to one word per cycle. ready = 0 throughout.
  - After the write to word DEPTH-1, the state moves to RUN.
- RUN: ready = 1 every cycle. Accepts one request per cycle with no back-pressure.

Reset behaviour:
- reset in any state, including mid-INIT, forces INIT with the counter at 0. Any partially cleared range is swept again.
- A load in flight when reset is asserted is discarded; rd_valid does not pulse.

Alignment check (on acceptance):
- Word access is legal only when addr[1:0] = 00.
- Halfword access is legal only when addr[0] = 0.
- Byte access is always legal.
- size = 11 is always illegal.
- An illegal access writes nothing, does not pulse rd_valid, and pulses addr_err on the next cycle.

Stores:
- Word address is addr[ADDR_W-1:2].
- Byte enables:
  - byte: 0001 shifted left by addr[1:0].
  - half: 0011 when addr[1] = 0, 1100 when addr[1] = 1.
  - word: 1111.
- Write data is replicated across lanes: byte → {4{wd[7:0]}}, half → {2{wd[15:0]}}, word → wd. Only enabled lanes change.
- There is no read-modify-write.

Loads:
- The RAM read is synchronous. addr[1:0], size and sign are registered alongside the read.
- Lane select:
  - byte: word[8*off+7 : 8*off], where off = addr[1:0].
  - half: word[15:0] when addr[1] = 0, word[31:16] when addr[1] = 1.
- Extension uses the sign input (sign-extend when 1, zero-extend when 0).

Output holding:
- rd holds its last value until the next legal load completes.
- rd is not cleared by stores or errors; only reset clears it.

Ordering:
- A load accepted in cycle N returns data that includes every store accepted in cycles before N.
- This includes a store to the same word in cycle N-1.

## Timing

- Reset values: ready = 0, rd_valid = 0, rd = 32'h0, addr_err = 0, INIT counter = 0.
- First cycle with ready = 1: exactly DEPTH cycles after the last cycle in which reset was high.
- Load latency: request accepted at edge N; rd_valid = 1 and rd valid after edge N+1, for one cycle.
- Back-to-back loads give back-to-back rd_valid pulses.
- Store latency: the word is updated at edge N. A load accepted at edge N+1 sees the new value.
- addr_err latency: asserted after edge N+1, for one cycle. rd_valid and addr_err are never both 1.
- req while ready = 0 is ignored. No request is queued.

## Test plan

- ADDR_W = 6 (16 words): deassert reset. ready stays 0 for exactly 16 cycles, then 1. Loading all 16 words returns 0 (overwrite them first with a pre-reset store pattern).
- Store word 32'h8899AABC at addr 0x08. Then:
  - lb at 0x08 → 32'hFFFFFFBC;
  - lbu at 0x09 → 32'h000000AA;
  - lh at 0x0A → 32'hFFFF8899;
  - lw at 0x08 → 32'h8899AABC.
  Each rd_valid arrives one cycle after its request.
- Store word 0 at 0x10, then sb wd = 32'h12345677 at 0x13, then sh wd = 32'h0000BEEF at 0x10. lw at 0x10 → 32'h7700BEEF.
- Misaligned accesses, each one cycle later giving addr_err = 1, rd_valid = 0, and leaving memory unchanged:
  - lw at 0x06;
  - sh at 0x05;
  - size = 11 at 0x00.
- Store at 0x20 in cycle N and load of 0x20 in cycle N+1 → the new data. Assert reset mid-INIT at count 7 → the sweep restarts from 0 and ready rises 16 cycles after reset falls.
